// File: rtl/decoder_pkg.sv
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared state type, output-width rule and one-hot helper for
//            the decoder_seq block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decoder_pkg;

  localparam int unsigned C_MAX_SEL_W = 6;
  localparam int unsigned C_MAX_OUT_W = 32'd1 << C_MAX_SEL_W;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic int unsigned out_width(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  function automatic logic [C_MAX_OUT_W-1:0] onehot(input logic [C_MAX_SEL_W-1:0] idx);
    logic [C_MAX_OUT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_onehot.sv
// ============================================================================
// Module   : decoder_onehot
// Brief    : Combinational SEL_W to 2^SEL_W one-hot decoder with enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decoder_onehot
  import decoder_pkg::*;
#(
  parameter  int SEL_W = 2,
  localparam int OUT_W = int'(out_width(SEL_W))
) (
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic [OUT_W-1:0] o_onehot
);

  assign o_onehot = i_en ? (OUT_W'(1) << i_sel) : '0;

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================================
// Module   : decoder_seq
// Brief    : Timed one-hot select sequencer (single / scan) with valid-ready
//            command port. Scan mode is built only with DECODER_SEQ_SCAN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W  = 2,
  parameter  int HOLD_W = 4,
  localparam int OUT_W  = int'(out_width(SEL_W))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [HOLD_W-1:0] in_hold,
  input  logic              in_mode,
  input  logic              in_abort,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_accept;
  logic              w_dec_en;
  logic [SEL_W-1:0]  w_dec_sel;
  logic [OUT_W-1:0]  w_dec_out;

  assign in_ready = !busy && !in_abort;
  assign w_accept = (r_state == IDLE) && in_valid && in_ready;
  assign w_dec_en = (r_state == IDLE) ? in_valid : 1'b1;

`ifdef DECODER_SEQ_SCAN_EN
  localparam logic [SEL_W-1:0] C_LAST_SLOT = '1;

  logic              r_mode;
  logic [SEL_W-1:0]  r_cur_idx;
  logic [SEL_W-1:0]  r_slot_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              w_step;

  assign w_step    = r_mode && (r_slot_cnt != C_LAST_SLOT);
  // Index wraps naturally in SEL_W bits, giving the modulo-2^SEL_W walk.
  assign w_dec_sel = (r_state == IDLE) ? in_sel : r_cur_idx + 1'b1;
`else
  logic w_unused_mode;

  assign w_unused_mode = in_mode;
  assign w_dec_sel     = in_sel;
`endif

  decoder_onehot #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .i_en     (w_dec_en),
    .i_sel    (w_dec_sel),
    .o_onehot (w_dec_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_hold_cnt <= '0;
`ifdef DECODER_SEQ_SCAN_EN
      r_mode     <= 1'b0;
      r_cur_idx  <= '0;
      r_slot_cnt <= '0;
      r_hold     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= ACTIVE;
            busy       <= 1'b1;
            out        <= w_dec_out;
            r_hold_cnt <= in_hold;
`ifdef DECODER_SEQ_SCAN_EN
            r_mode     <= in_mode;
            r_cur_idx  <= in_sel;
            r_slot_cnt <= '0;
            r_hold     <= in_hold;
`endif
          end
        end
        ACTIVE: begin
          if (in_abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            out     <= '0;
          end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
`ifdef DECODER_SEQ_SCAN_EN
          end else if (w_step) begin
            r_cur_idx  <= r_cur_idx + 1'b1;
            out        <= w_dec_out;
            r_hold_cnt <= r_hold;
            r_slot_cnt <= r_slot_cnt + 1'b1;
`endif
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
            out     <= '0;
            done    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================================
// Module   : tb_decoder_seq
// Brief    : Self-checking bench for decoder_seq against a list-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decoder_seq;

  localparam int SEL_W  = 2;
  localparam int HOLD_W = 4;
  localparam int N      = 4;
`ifdef DECODER_SEQ_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel   = '0;
  logic [HOLD_W-1:0] in_hold  = '0;
  logic              in_mode  = 1'b0;
  logic              in_abort = 1'b0;
  logic [N-1:0]      out;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  decoder_seq #(
    .SEL_W  (SEL_W),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_hold  (in_hold),
    .in_mode  (in_mode),
    .in_abort (in_abort),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model: on accept, the full list of per-cycle select values is expanded up front.
  logic [N-1:0] m_out  = '0;
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  logic [N-1:0] m_rem[$];

  task automatic model_reset();
    m_rem.delete();
    m_out  = '0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] sel, input logic [3:0] hold,
                            input bit mode, input bit abort);
    if (m_busy) begin
      if (abort) begin
        model_reset();
      end else if (m_rem.size() > 0) begin
        m_out  = m_rem.pop_front();
        m_done = 1'b0;
      end else begin
        m_out  = '0;
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (v && !abort) begin
        int slots;
        slots = (SCAN_EN && mode) ? N : 1;
        m_rem.delete();
        for (int k = 0; k < slots; k++)
          for (int c = 0; c <= int'(hold); c++)
            m_rem.push_back(N'(1) << ((int'(sel) + k) % N));
        m_out  = m_rem.pop_front();
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [1:0] sel, input logic [3:0] hold,
                       input bit mode, input bit abort);
    in_valid = v;
    in_sel   = sel;
    in_hold  = hold;
    in_mode  = mode;
    in_abort = abort;
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_busy && !abort));
    @(posedge clk);
    model_edge(v, sel, hold, mode, abort);
    #1;
    check("out", 64'(out), 64'(m_out));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("onehot", 64'($countones(out) <= 1), 64'(1));
  endtask

  initial begin
    #12;
    check("rst_out", 64'(out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Single 1-cycle slot
    cycle(1, 2'd2, 4'd0, 0, 0);
    repeat (2) cycle(0, 2'd0, 4'd0, 0, 0);

    // 4-cycle slot with in_sel changing mid-command
    cycle(1, 2'd1, 4'd3, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 2'(i), 4'd0, 1, 0);
    repeat (2) cycle(0, 2'd0, 4'd0, 0, 0);

    // Scan with wrap from index 3
    cycle(1, 2'd3, 4'd1, 1, 0);
    repeat (9) cycle(0, 2'd0, 4'd0, 0, 0);

    // Back-to-back commands with in_valid held high
    for (int i = 0; i < 10; i++) cycle(1, 2'($urandom_range(0, 3)), 4'd0, 0, 0);
    cycle(0, 2'd0, 4'd0, 0, 0);
    cycle(0, 2'd0, 4'd0, 0, 0);

    // Abort on second cycle, then abort with valid in IDLE
    cycle(1, 2'd0, 4'd3, 0, 0);
    cycle(0, 2'd0, 4'd0, 0, 1);
    repeat (2) cycle(0, 2'd0, 4'd0, 0, 0);
    cycle(1, 2'd2, 4'd0, 0, 1);
    cycle(0, 2'd0, 4'd0, 0, 0);

    // Reset mid-scan
    cycle(1, 2'd1, 4'd2, 1, 0);
    repeat (3) cycle(0, 2'd0, 4'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 64'(out), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 2'd3, 4'd1, 0, 0);
    repeat (3) cycle(0, 2'd0, 4'd0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] h;
      h = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), h,
            bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decoder_seq.md
# decoder_seq

Parametrised SEL_W-to-2^SEL_W one-hot decoder with a registered, timed output and a valid/ready command port. Each accepted command drives one output line for a programmable number of cycles (single mode) or walks every line in turn starting at the commanded index (scan mode). It sits between control logic and strobe, chip-select or row-select fan-out, where a bare combinational decoder cannot hold or sequence selects.

## Interface
- SEL_W, 2: select width; output width is 2^SEL_W (legal range 1..6)
- HOLD_W, 4: width of the per-slot hold count
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  command accepted when in_valid && in_ready at a rising edge
- in_sel  in  SEL_W  start index
- in_hold  in  HOLD_W  slot length minus one (0 gives a 1-cycle slot)
- in_mode  in  1  0 = single, 1 = scan
- in_abort  in  1  synchronous cancel
- out  out  2^SEL_W  registered one-hot select, or all zeros
- busy  out  1  registered; high while in ACTIVE
- done  out  1  registered one-cycle pulse when a command completes normally

## Operation
- Two states: IDLE and ACTIVE.
- Registered state: out, busy, done, cur_idx, hold_r, hold_cnt, slot_cnt, mode_r.
- Combinational ready: in_ready = !busy && !in_abort.
- **Accept (IDLE, in_valid && in_ready):**
  - go to ACTIVE
  - out <= onehot(in_sel); cur_idx <= in_sel
  - hold_r <= in_hold; hold_cnt <= in_hold
  - slot_cnt <= 0; mode_r <= in_mode
- **ACTIVE, priority order at each edge:**
  1. in_abort: out <= 0, go to IDLE, done stays 0.
  2. hold_cnt != 0: hold_cnt decrements.
  3. mode_r == 1 and slot_cnt != 2^SEL_W-1: cur_idx <= cur_idx+1, with modulo 2^SEL_W wrap; out <= onehot(cur_idx+1); hold_cnt <= hold_r; slot_cnt increments.
  4. Otherwise: out <= 0, go to IDLE, done <= 1.
- done is 0 on every edge except the completion edge in step 4.
- Inputs are sampled only at accept. Changes to in_sel, in_hold or in_mode while ACTIVE are ignored.
- out is never multi-hot. During IDLE, out is all zeros.
- Reset values: out = 0, busy = 0, done = 0, state IDLE, all counters 0. in_ready is therefore 1 whenever in_abort is low.
- Reset mid-command clears all registers immediately. No done pulse is generated.

## Timing
- Select latency: out is valid in the cycle after the accepting edge.
- Single mode: out is high for in_hold+1 cycles.
- Scan mode: 2^SEL_W consecutive slots of in_hold+1 cycles each, with no zero gap between slots. Total is 2^SEL_W × (in_hold+1) cycles.
- done is high in the first cycle with out = 0, and busy is low in that same cycle.
- Because in_ready is high in that cycle, a back-to-back command is accepted there. The minimum gap of out = 0 between commands is one cycle.
- Abort in IDLE blocks acceptance for that cycle only; nothing else changes.
- Wrap example, SEL_W = 2, in_sel = 3, scan mode: indices 3, 0, 1, 2.

## Configuration
- DECODER_SEQ_SCAN_EN defined:
  - scan mode is available
  - slot_cnt and the cur_idx increment logic are present
- DECODER_SEQ_SCAN_EN undefined:
  - the in_mode port remains but is ignored and mode_r is tied to 0
  - slot_cnt and the increment logic are not built
  - every command behaves as single mode

## Structure
- Package decoder_pkg holds:
  - the state enum typedef (IDLE, ACTIVE)
  - the localparam form of the output-width rule (2^SEL_W)
  - the onehot function (index to one-hot vector)
- Sub-module decoder_onehot is the purely combinational SEL_W to 2^SEL_W decoder with enable. It drives the next-out value and is reusable standalone.

## Test plan
- Reset, then SEL_W = 2, in_sel = 2, in_hold = 0, single mode -> out = 4'b0100 for exactly 1 cycle, then 4'b0000 with done = 1 for one cycle.
- in_sel = 1, in_hold = 3, single mode -> out = 4'b0010 for 4 cycles. in_ready = 0 and busy = 1 throughout. Changing in_sel mid-command has no effect.
- Scan mode, in_sel = 3, in_hold = 1 -> out sequence 1000, 1000, 0001, 0001, 0010, 0010, 0100, 0100, then 0000 with done = 1 (8 active cycles).
- in_valid held high continuously with in_hold = 0, single mode -> a new command is accepted on every done cycle. out alternates one-hot/zero, and is never high on two consecutive cycles.
- Abort on the 2nd cycle of a 4-cycle single command -> out = 0 the next cycle, done never pulses, in_ready = 1 after in_abort falls. Abort together with in_valid in IDLE -> no accept.
- Assert rst_n low mid-scan -> out, busy and done are 0 asynchronously. After release, the block is IDLE and the next command behaves normally.
